// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave): single-outstanding read/write requests and a response strobe.
interface data_mem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_d_MemRead;
  logic              i_d_MemWrite;
  logic [ADDR_W-1:0] i_d_r_addr;
  logic [ADDR_W-1:0] i_d_w_addr;
  logic [DATA_W-1:0] i_d_w_data;
  logic [DATA_W-1:0] o_d_data;
  logic              o_d_valid;
  logic              o_d_err;
  logic              o_d_busy;
  logic              o_d_overrun;

  modport master (
    output i_d_MemRead, i_d_MemWrite, i_d_r_addr, i_d_w_addr, i_d_w_data,
    input  o_d_data, o_d_valid, o_d_err, o_d_busy, o_d_overrun
  );

  modport slave (
    input  i_d_MemRead, i_d_MemWrite, i_d_r_addr, i_d_w_addr, i_d_w_data,
    output o_d_data, o_d_valid, o_d_err, o_d_busy, o_d_overrun
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: DEPTH doublewords, one request at a time, registered
// response (read data or write ack, with error flag) LATENCY cycles after accept.
module data_mem_responder #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  data_mem_responder_if.slave  bus
);
  localparam int BPW      = DATA_W / 8;
  localparam int BPW_LOG2 = $clog2(BPW);
  localparam int IDX_W    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, pend_data_q;
  logic              valid_q, err_q, overrun_q;
  logic              pend_err_q, pend_upd_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  r_idx, w_idx;
  logic              r_oor, w_oor;
  logic              req, accept, mem_we;
  logic              cur_err;
  logic [DATA_W-1:0] cur_rdata;
  logic              resp_err, resp_upd;
  logic [DATA_W-1:0] resp_data;
  logic              unused_addr_lsbs;

  // Byte offset within a word is deliberately ignored (no misalignment check).
  assign unused_addr_lsbs = ^{bus.i_d_r_addr[BPW_LOG2-1:0], bus.i_d_w_addr[BPW_LOG2-1:0]};

  assign r_idx = bus.i_d_r_addr[BPW_LOG2 +: IDX_W];
  assign w_idx = bus.i_d_w_addr[BPW_LOG2 +: IDX_W];
  assign r_oor = |bus.i_d_r_addr[ADDR_W-1:BPW_LOG2+IDX_W];
  assign w_oor = |bus.i_d_w_addr[ADDR_W-1:BPW_LOG2+IDX_W];

  assign req       = bus.i_d_MemRead | bus.i_d_MemWrite;
  assign cur_err   = (bus.i_d_MemRead & bus.i_d_MemWrite) |
                     (bus.i_d_MemRead & r_oor) | (bus.i_d_MemWrite & w_oor);
  assign cur_rdata = (bus.i_d_MemRead && !cur_err) ? mem[r_idx] : '0;
  assign mem_we    = accept & bus.i_d_MemWrite & ~cur_err & ~i_rst;

  // A LATENCY=1 response leaves IDLE straight into RESP, so it takes the live
  // request's result; longer latencies use what was captured at accept.
  assign resp_err  = (state_q == IDLE) ? cur_err           : pend_err_q;
  assign resp_upd  = (state_q == IDLE) ? bus.i_d_MemRead   : pend_upd_q;
  assign resp_data = (state_q == IDLE) ? cur_rdata         : pend_data_q;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      pend_upd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == RESP);
      err_q   <= (state_d == RESP) & resp_err;
      if (state_d == RESP && resp_upd) data_q <= resp_data;
      if (accept) begin
        pend_err_q  <= cur_err;
        pend_upd_q  <= bus.i_d_MemRead;
        pend_data_q <= cur_rdata;
      end
      if (req && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; contents survive i_rst and only writes change them.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[w_idx] <= bus.i_d_w_data;
  end

  assign bus.o_d_data    = data_q;
  assign bus.o_d_valid   = valid_q;
  assign bus.o_d_err     = err_q;
  assign bus.o_d_busy    = (state_q != IDLE);
  assign bus.o_d_overrun = overrun_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: drives one LATENCY=2 and one LATENCY=1 responder with the same
// stimulus and checks whichever one is currently selected.
module tb_data_mem_responder;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] VA   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VB   = 64'h5555_6666_7777_8888;
  localparam logic [63:0] VC   = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] VD   = 64'h0F0F_F0F0_1234_ABCD;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [63:0] ra, wa, wd;
  logic        sel;
  int          lat;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [63:0] o_data;
  logic        o_valid, o_err, o_busy, o_overrun;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(64), .DATA_W(64)) if2 ();
  data_mem_responder_if #(.ADDR_W(64), .DATA_W(64)) if1 ();

  data_mem_responder #(.LATENCY(2)) dut_l2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
  data_mem_responder #(.LATENCY(1)) dut_l1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));

  assign if2.i_d_MemRead  = rd;
  assign if2.i_d_MemWrite = wr;
  assign if2.i_d_r_addr   = ra;
  assign if2.i_d_w_addr   = wa;
  assign if2.i_d_w_data   = wd;
  assign if1.i_d_MemRead  = rd;
  assign if1.i_d_MemWrite = wr;
  assign if1.i_d_r_addr   = ra;
  assign if1.i_d_w_addr   = wa;
  assign if1.i_d_w_data   = wd;

  assign o_data    = sel ? if1.o_d_data    : if2.o_d_data;
  assign o_valid   = sel ? if1.o_d_valid   : if2.o_d_valid;
  assign o_err     = sel ? if1.o_d_err     : if2.o_d_err;
  assign o_busy    = sel ? if1.o_d_busy    : if2.o_d_busy;
  assign o_overrun = sel ? if1.o_d_overrun : if2.o_d_overrun;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL L%0d %s: got %h expected %h", lat, tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " valid"},   64'(o_valid),   64'd0);
    check({tag, " err"},     64'(o_err),     64'd0);
    check({tag, " data"},    o_data,         64'd0);
    check({tag, " busy"},    64'(o_busy),    64'd0);
    check({tag, " overrun"}, 64'(o_overrun), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
  endtask

  // Issue one request and check the response window edge by edge.
  task automatic do_req(input string tag, input logic r, input logic w,
                        input logic [63:0] a_r, input logic [63:0] a_w, input logic [63:0] d,
                        input logic e_err, input logic [63:0] e_data);
    @(negedge clk);
    rd = r; wr = w; ra = a_r; wa = a_w; wd = d;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    check({tag, " busy"}, 64'(o_busy), 64'd1);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      if (k == lat - 1) begin
        check({tag, " valid"}, 64'(o_valid), 64'd1);
        check({tag, " err"},   64'(o_err),   64'(e_err));
        check({tag, " data"},  o_data,       e_data);
      end else begin
        check({tag, " no valid"}, 64'(o_valid), 64'd0);
      end
    end
    check({tag, " idle"}, 64'(o_busy), 64'd0);
  endtask

  task automatic overrun_test();
    int nv;
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; ra = 64'h10;
    @(posedge clk);
    @(negedge clk);
    check("ovr before", 64'(o_overrun), 64'd0);
    nv = int'(o_valid);
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    nv += int'(o_valid);
    check("ovr set", 64'(o_overrun), 64'd1);
    repeat (lat + 2) begin
      @(negedge clk);
      nv += int'(o_valid);
    end
    check("ovr single valid", 64'(nv), 64'd1);
    check("ovr data", o_data, DEAD);
    do_req("ovr next rd", 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, VA);
    check("ovr sticky", 64'(o_overrun), 64'd1);
  endtask

  task automatic rst_mid(input string tag, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
    int nv;
    @(negedge clk);
    rd = r; wr = w; ra = a; wa = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero(tag);
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      nv += int'(o_valid);
    end
    check({tag, " dropped"}, 64'(nv), 64'd0);
  endtask

  task automatic run_suite();
    do_req("wr 0x10",   1'b0, 1'b1, 64'h0,   64'h10,  DEAD, 1'b0, 64'h0);
    do_req("rd 0x10",   1'b1, 1'b0, 64'h10,  64'h0,   64'h0, 1'b0, DEAD);
    do_req("rd 0x17",   1'b1, 1'b0, 64'h17,  64'h0,   64'h0, 1'b0, DEAD);
    do_req("wr 0x0",    1'b0, 1'b1, 64'h0,   64'h0,   VA,   1'b0, DEAD);
    do_req("wr 0x7f8",  1'b0, 1'b1, 64'h0,   64'h7F8, VB,   1'b0, DEAD);
    do_req("rd 0x800",  1'b1, 1'b0, 64'h800, 64'h0,   64'h0, 1'b1, 64'h0);
    do_req("wr 0x800",  1'b0, 1'b1, 64'h0,   64'h800, VC,   1'b1, 64'h0);
    do_req("rd 0x0",    1'b1, 1'b0, 64'h0,   64'h0,   64'h0, 1'b0, VA);
    do_req("rd 0x7f8",  1'b1, 1'b0, 64'h7F8, 64'h0,   64'h0, 1'b0, VB);
    do_req("rd+wr",     1'b1, 1'b1, 64'h10,  64'h10,  VC,   1'b1, 64'h0);
    do_req("rd 0x10 b", 1'b1, 1'b0, 64'h10,  64'h0,   64'h0, 1'b0, DEAD);
    overrun_test();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    ra = '0; wa = '0; wd = '0;
    sel = 1'b0; lat = 2;
    apply_reset();
    run_suite();
    rst_mid("rst rd", 1'b1, 1'b0, 64'h10, 64'h0);
    do_req("after rst rd", 1'b1, 1'b0, 64'h10, 64'h0, 64'h0, 1'b0, DEAD);
    rst_mid("rst wr", 1'b0, 1'b1, 64'h20, VD);
    do_req("committed wr", 1'b1, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0, VD);

    sel = 1'b1; lat = 1;
    apply_reset();
    run_suite();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
